muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit with HI/LO registers for the pipelined CPU, sitting beside the ALU in the EX stage. It schedules the multi-cycle operation itself and raises a stall request that the hazard logic ORs into its PC / IF-ID / ID-EX hold conditions. While an operation is running, any HI/LO access or new mult/div waits in EX until the unit is idle.

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// One result bit per cycle: WIDTH CALC cycles, then a FIX cycle that applies
// the sign correction and writes HI/LO. Raises a combinational stall while busy.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_hi,
    input  logic             rd_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [CNT_W-1:0]  cnt;
    logic              is_div;
    logic              neg_res;
    logic              neg_rem;
    logic              div_zero;
    logic [WIDTH-1:0]  a_raw;
    logic [WIDTH-1:0]  opnd;
    logic [ACC_W-1:0]  acc;

    logic              sgn_in;
    logic [WIDTH-1:0]  abs_a;
    logic [WIDTH-1:0]  abs_b;

    logic [WIDTH:0]    mul_sum;
    logic [ACC_W-1:0]  mul_next;
    logic [WIDTH:0]    div_sh;
    logic [WIDTH:0]    div_diff;
    logic [ACC_W-1:0]  div_next;

    logic [ACC_W-1:0]  prod_fix;
    logic [WIDTH-1:0]  quo_fix;
    logic [WIDTH-1:0]  rem_fix;
    logic [WIDTH-1:0]  res_hi;
    logic [WIDTH-1:0]  res_lo;

    // Operand magnitudes at issue; op[0]=0 selects the signed variants
    always_comb begin
        sgn_in = ~op[0];
        abs_a  = (sgn_in && a[WIDTH-1]) ? -a : a;
        abs_b  = (sgn_in && b[WIDTH-1]) ? -b : b;
    end

    // One shift-add multiply step: acc = {partial product, remaining multiplier}
    always_comb begin
        mul_sum  = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // One restoring divide step: acc = {remainder, dividend shifting into quotient}
    always_comb begin
        div_sh   = acc[ACC_W-1:WIDTH-1];
        div_diff = div_sh - {1'b0, opnd};
        if (div_diff[WIDTH]) begin
            div_next = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction and HI/LO selection for the FIX cycle
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[ACC_W-1:WIDTH] : acc[ACC_W-1:WIDTH];
        if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else if (is_div) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end else begin
            res_hi = prod_fix[ACC_W-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CNT_LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs; stall has no register stage so PC holds the same cycle
    always_comb begin
        busy  = (state != IDLE);
        done  = (state == FIX);
        stall = busy & (start | wr_hi | wr_lo | rd_hi | rd_lo);
    end

    // Datapath: operand latch, iteration, HI/LO writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            opnd     <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_res  <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem  <= sgn_in & a[WIDTH-1];
                        div_zero <= op[1] & (b == '0);
                        a_raw    <= a;
                        // multiply adds |a| while walking |b|; divide subtracts |b| from |a|
                        opnd     <= op[1] ? abs_b : abs_a;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus stall/write/reset sequences.
module tb_muldiv_unit;

    localparam int unsigned W = 32;
    localparam int NV = 12;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wdata;
    logic         rd_hi;
    logic         rd_lo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t tbl [NV];

    int n_pass  = 0;
    int n_total = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .rd_hi (rd_hi),
        .rd_lo (rd_lo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .stall (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op from the current cycle (called #1 after an edge); returns
    // #1 after the edge where busy falls, i.e. when the result is readable.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int busy_cycles, output int done_cnt);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        busy_cycles = 0;
        done_cnt    = 0;
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            busy_cycles++;
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    initial begin : main
        int bc;
        int dc;
        int busy_err;
        int stall_err;
        logic exp_busy;
        logic exp_stall;

        tbl[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        tbl[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[5]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        tbl[6]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        tbl[7]  = '{2'b00, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        tbl[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tbl[9]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[10] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        tbl[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wdata = '0;
        rd_hi = 1'b0;
        rd_lo = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;

        // Vector table, issued back to back (start in the cycle after done)
        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, bc, dc);
            check($sformatf("v%0d_hi", i), hi, tbl[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, tbl[i].exp_lo);
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd33);
            check($sformatf("v%0d_done_pulses", i), 32'(dc), 32'd1);
        end

        // mflo from 5 cycles after start, a second start and an mthi while busy
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd4;
        @(posedge clk); #1;
        busy_err  = 0;
        stall_err = 0;
        for (int c = 1; c <= 34; c++) begin
            rd_lo = (c >= 5);
            start = (c == 10);
            op    = 2'b11;
            a     = 32'd1;
            b     = 32'd1;
            wr_hi = (c == 15);
            wdata = 32'hDEADBEEF;
            #1;
            exp_busy  = (c <= 33);
            exp_stall = exp_busy & (rd_lo | start | wr_hi);
            if (busy !== exp_busy) busy_err++;
            if (stall !== exp_stall) stall_err++;
            if (c == 16) check("mthi_busy_dropped", hi, tbl[NV-1].exp_hi);
            if (c != 34) begin
                @(posedge clk); #1;
            end
        end
        check("stall_seq_busy_errs", 32'(busy_err), 32'd0);
        check("stall_seq_stall_errs", 32'(stall_err), 32'd0);
        check("stall_seq_lo", lo, 32'd12);
        check("stall_seq_hi", hi, 32'd0);
        rd_lo = 1'b0;
        start = 1'b0;
        wr_hi = 1'b0;

        // Idle mtlo, then mthi+mtlo together
        wr_lo = 1'b1;
        wdata = 32'hCAFEBABE;
        #1 check("mtlo_idle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        wr_lo = 1'b0;
        check("mtlo_lo", lo, 32'hCAFEBABE);
        check("mtlo_hi_kept", hi, 32'd0);
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'h11112222;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        check("mt_both_hi", hi, 32'h11112222);
        check("mt_both_lo", lo, 32'h11112222);

        // start with wr_hi in IDLE: start wins, write dropped
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd2;
        b     = 32'd3;
        wr_hi = 1'b1;
        wdata = 32'hFFFF0000;
        @(posedge clk); #1;
        start = 1'b0;
        wr_hi = 1'b0;
        check("start_wins_hi", hi, 32'h11112222);
        check("start_wins_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        check("start_wins_busy_end", 32'(busy), 32'd0);
        check("start_wins_lo", lo, 32'd6);
        check("start_wins_res_hi", hi, 32'd0);

        // Reset 10 cycles into a div
        wr_hi = 1'b1;
        wdata = 32'hABCD0000;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd100;
        b     = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rd_hi = 1'b1;
        #1 check("pre_reset_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_stall", 32'(stall), 32'd0);
        check("mid_reset_done", 32'(done), 32'd0);
        check("mid_reset_hi", hi, 32'd0);
        check("mid_reset_lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rd_hi = 1'b0;
        run_op(2'b11, 32'd100, 32'd7, bc, dc);
        check("post_reset_lo", lo, 32'd14);
        check("post_reset_hi", hi, 32'd2);
        check("post_reset_busy_cycles", 32'(bc), 32'd33);
        check("post_reset_done_pulses", 32'(dc), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
